pll_clken_gen: RTL

Multi-channel clock-enable generator that sits directly behind the fabric PLL. It qualifies the PLL lock with a stability window and releases a synchronised downstream reset. It then produces NUM_CH independent, runtime-programmable clock-enable pulse streams using phase accumulators, e.g. 800 kHz WS2812 bit timing from a 100 MHz refclk. Lock loss is detected, held in a sticky flag and forces a safe re-sequence.

---
 rtl/pll_clkgen_pkg.sv | 22 ++
 rtl/pll_clken_gen_phase_acc_ch.sv | 41 ++++
 rtl/pll_clken_gen.sv | 94 +++++++++
 3 files changed

// File: rtl/pll_clkgen_pkg.sv
// rtl/pll_clkgen_pkg.sv - shared FSM type, default increment and increment helper
package pll_clkgen_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABLE    = 2'd1,
      RUN       = 2'd2
   } lock_state_e;

   // 800 kHz from a 100 MHz refclk with a 32-bit accumulator
   localparam logic [31:0] INC_DEFAULT = 32'd34359738;

   // inc = floor(target_hz * 2^acc_w / ref_hz)
   function automatic logic [63:0] calc_inc(input logic [31:0] target_hz,
                                            input logic [31:0] ref_hz,
                                            input int unsigned acc_w);
      logic [63:0] num;
      num = {32'd0, target_hz} << acc_w;
      return num / {32'd0, ref_hz};
   endfunction

endpackage

// File: rtl/pll_clken_gen_phase_acc_ch.sv
// rtl/pll_clken_gen_phase_acc_ch.sv - one channel: increment register, phase accumulator, registered carry
module phase_acc_ch #(
   parameter int               ACC_W     = 32,
   parameter logic [ACC_W-1:0] INC_RESET = '0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             clr,
   input  logic             we,
   input  logic [ACC_W-1:0] inc_in,
   output logic             ce
);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] inc;
   logic [ACC_W:0]   sum;

   assign sum = {1'b0, acc} + {1'b0, inc};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         inc <= INC_RESET;
         ce  <= 1'b0;
      end else begin
         if (we) begin
            inc <= inc_in;
         end
         // the carry out of the wrapping add is the enable pulse
         if (!run || clr) begin
            acc <= '0;
            ce  <= 1'b0;
         end else begin
            acc <= sum[ACC_W-1:0];
            ce  <= sum[ACC_W];
         end
      end
   end

endmodule

// File: rtl/pll_clken_gen.sv
// rtl/pll_clken_gen.sv - PLL lock qualification, downstream reset release and multi-channel clock enables
module pll_clken_gen
   import pll_clkgen_pkg::*;
#(
   parameter int               NUM_CH             = 2,
   parameter int               ACC_W              = 32,
   parameter int               LOCK_STABLE_CYCLES = 1024,
   parameter logic [ACC_W-1:0] INC_RESET          = ACC_W'(INC_DEFAULT),
   localparam int              CH_W               = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              refclk,
   input  logic              rst,
   input  logic              pll_locked,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [ACC_W-1:0]  cfg_inc,
   input  logic              sync_clr,
   input  logic              lock_lost_clr,
   output logic [NUM_CH-1:0] ce_out,
   output logic              rst_out_n,
   output logic              ready,
   output logic              lock_lost
);

   localparam int CNT_W = $clog2(LOCK_STABLE_CYCLES);

   lock_state_e      state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             sync1, lk_s;
   logic             run_en, lock_drop;

   assign run_en    = (state_q == RUN) && lk_s;
   assign lock_drop = (state_q == RUN) && !lk_s;

   always_comb begin
      state_d = state_q;
      cnt_d   = '0;
      case (state_q)
         WAIT_LOCK: if (lk_s) state_d = STABLE;
         STABLE: begin
            if (!lk_s) begin
               state_d = WAIT_LOCK;
            end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
               state_d = RUN;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         RUN:     if (!lk_s) state_d = WAIT_LOCK;
         default: state_d = WAIT_LOCK;
      endcase
   end

   always_ff @(posedge refclk or negedge rst) begin
      if (!rst) begin
         sync1     <= 1'b0;
         lk_s      <= 1'b0;
         state_q   <= WAIT_LOCK;
         cnt_q     <= '0;
         rst_out_n <= 1'b0;
         ready     <= 1'b0;
         lock_lost <= 1'b0;
      end else begin
         sync1     <= pll_locked;
         lk_s      <= sync1;
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         // decoded from next state so both rise together with the first RUN cycle
         rst_out_n <= (state_d == RUN);
         ready     <= (state_d == RUN);
         if (lock_drop) begin
            lock_lost <= 1'b1;
         end else if (lock_lost_clr) begin
            lock_lost <= 1'b0;
         end
      end
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      phase_acc_ch #(
         .ACC_W     (ACC_W),
         .INC_RESET (INC_RESET)
      ) u_ch (
         .clk    (refclk),
         .rst_n  (rst),
         .run    (run_en),
         .clr    (sync_clr),
         .we     (cfg_we && (cfg_ch == CH_W'(i))),
         .inc_in (cfg_inc),
         .ce     (ce_out[i])
      );
   end

endmodule
